// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types, default widths and helpers for the SRAM arbiter
package sram_arb_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 14;
    localparam int SRAM_LAT_DEF = 1;

    typedef enum logic {REQ_CPU = 1'b0, REQ_LDR = 1'b1} req_id_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } sram_cmd_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_CPU) ? REQ_LDR : REQ_CPU;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: shift register of {valid, owner} that follows each read through the SRAM latency
module rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    i_rst_n,
    input  logic    i_push,
    input  req_id_t i_id,
    output logic    o_valid,
    output req_id_t o_id,
    output logic    o_any
);

    logic [DEPTH-1:0] r_valid;
    req_id_t          r_id [DEPTH];

    // shift tags one stage per cycle; clearing drops every in-flight read
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) r_id[k] <= REQ_CPU;
        end else begin
            r_valid[0] <= i_push;
            r_id[0]    <= i_id;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_id[k]    <= r_id[k-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_id    = r_id[DEPTH-1];
    assign o_any   = |r_valid;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin CPU/loader arbiter driving a single-port synchronous SRAM
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SRAM_LAT = SRAM_LAT_DEF
) (
    input  logic              clk,
    input  logic              RST_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              cpu_gnt,
    output logic              ldr_gnt,
    output logic              cpu_rvalid,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]        r_state;
    req_id_t           r_rr;
    req_id_t           r_owner;
    logic              r_cpu_gnt;
    logic              r_ldr_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_cpu_rvalid;
    logic              r_ldr_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;

    logic              w_cpu_elig;
    logic              w_ldr_elig;
    logic              w_issue;
    req_id_t           w_win;
    logic              w_rd_push;
    logic              w_tag_valid;
    req_id_t           w_tag_id;
    logic              w_tag_any;

    // a requester whose gnt is high is masked so a held req is not issued twice
    always_comb begin
        w_cpu_elig = cpu_req && !r_cpu_gnt;
        w_ldr_elig = ldr_req && !r_ldr_gnt;
        w_issue    = w_cpu_elig || w_ldr_elig;
        w_win      = (w_cpu_elig && w_ldr_elig) ? r_rr : (w_ldr_elig ? REQ_LDR : REQ_CPU);
    end

    // register the winning command onto the SRAM pins together with its gnt
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= ST_IDLE;
            r_rr      <= REQ_CPU;
            r_owner   <= REQ_CPU;
            r_cpu_gnt <= 1'b0;
            r_ldr_gnt <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_issue ? ST_ISSUE : ST_IDLE;
            r_cpu_gnt <= w_issue && (w_win == REQ_CPU);
            r_ldr_gnt <= w_issue && (w_win == REQ_LDR);
            r_we      <= w_issue && ((w_win == REQ_LDR) ? ldr_we : cpu_we);
            if (w_issue) begin
                r_rr    <= other_req(w_win);
                r_owner <= w_win;
                r_addr  <= (w_win == REQ_LDR) ? ldr_addr : cpu_addr;
                r_wdata <= (w_win == REQ_LDR) ? ldr_wdata : cpu_wdata;
            end
        end
    end

    assign w_rd_push = (r_state == ST_ISSUE) && !r_we;

    rd_tag_pipe #(
        .DEPTH(SRAM_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .i_rst_n(RST_n),
        .i_push (w_rd_push),
        .i_id   (r_owner),
        .o_valid(w_tag_valid),
        .o_id   (w_tag_id),
        .o_any  (w_tag_any)
    );

    // capture returning read data into the owning port when its tag emerges
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ldr_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= w_tag_valid && (w_tag_id == REQ_CPU);
            r_ldr_rvalid <= w_tag_valid && (w_tag_id == REQ_LDR);
            if (w_tag_valid && (w_tag_id == REQ_CPU)) r_cpu_rdata <= sram_rdata;
            if (w_tag_valid && (w_tag_id == REQ_LDR)) r_ldr_rdata <= sram_rdata;
        end
    end

    assign cpu_gnt    = r_cpu_gnt;
    assign ldr_gnt    = r_ldr_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign ldr_rvalid = r_ldr_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign ldr_rdata  = r_ldr_rdata;
    assign sram_ce    = (r_state == ST_ISSUE);
    assign sram_we    = r_we;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign busy       = sram_ce || w_tag_any;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of two arbiters (SRAM_LAT=1 and 3) driven by the same stimulus
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        RST_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
    logic [13:0] cpu_addr = '0, ldr_addr = '0;
    logic [15:0] cpu_wdata = '0, ldr_wdata = '0;

    logic        cpu_gnt1, ldr_gnt1, cpu_rvalid1, ldr_rvalid1, ce1, we1, busy1;
    logic [15:0] cpu_rdata1, ldr_rdata1, wdata1, rdata1;
    logic [13:0] addr1;
    logic        cpu_gnt3, ldr_gnt3, cpu_rvalid3, ldr_rvalid3, ce3, we3, busy3;
    logic [15:0] cpu_rdata3, ldr_rdata3, wdata3, rdata3;
    logic [13:0] addr3;

    logic [15:0] mem1 [0:16383];
    logic [15:0] mem3 [0:16383];
    logic [15:0] rp1;
    logic [15:0] rp3 [0:2];

    int checks = 0;
    int fails  = 0;
    int ng;

    always #5 clk = ~clk;

    sram_arbiter #(.DATA_W(16), .ADDR_W(14), .SRAM_LAT(1)) u1 (
        .clk(clk), .RST_n(RST_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .cpu_gnt(cpu_gnt1), .ldr_gnt(ldr_gnt1), .cpu_rvalid(cpu_rvalid1), .ldr_rvalid(ldr_rvalid1),
        .cpu_rdata(cpu_rdata1), .ldr_rdata(ldr_rdata1),
        .sram_ce(ce1), .sram_we(we1), .sram_addr(addr1), .sram_wdata(wdata1),
        .sram_rdata(rdata1), .busy(busy1)
    );

    sram_arbiter #(.DATA_W(16), .ADDR_W(14), .SRAM_LAT(3)) u3 (
        .clk(clk), .RST_n(RST_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .cpu_gnt(cpu_gnt3), .ldr_gnt(ldr_gnt3), .cpu_rvalid(cpu_rvalid3), .ldr_rvalid(ldr_rvalid3),
        .cpu_rdata(cpu_rdata3), .ldr_rdata(ldr_rdata3),
        .sram_ce(ce3), .sram_we(we3), .sram_addr(addr3), .sram_wdata(wdata3),
        .sram_rdata(rdata3), .busy(busy3)
    );

    // SRAM models: data for a command in cycle c appears on rdata in cycle c+LAT
    always @(posedge clk) begin
        if (ce1 && we1) mem1[addr1] <= wdata1;
        rp1 <= mem1[addr1];
        if (ce3 && we3) mem3[addr3] <= wdata3;
        rp3[0] <= mem3[addr3];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign rdata1 = rp1;
    assign rdata3 = rp3[2];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic ldr, input logic [13:0] a, input logic [15:0] d);
        if (ldr) begin
            ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = a; ldr_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        end
        tick;
        chk(ldr ? "wr_ldr_gnt" : "wr_cpu_gnt", {ldr_gnt1, cpu_gnt1, ce1, we1}, {ldr, !ldr, 2'b11});
        chk("wr_addr_data", {addr1, wdata1}, {a, d});
        ldr_req = 1'b0;
        cpu_req = 1'b0;
        tick;
    endtask

    initial begin
        // reset values
        tick;
        tick;
        chk("rst_gnt_rvalid", {cpu_gnt1, ldr_gnt1, cpu_rvalid1, ldr_rvalid1}, 4'b0000);
        chk("rst_rdata", {cpu_rdata1, ldr_rdata1}, 32'h0);
        chk("rst_sram", {ce1, we1, addr1, wdata1, busy1}, 33'h0);
        chk("rst_lat3", {ce3, busy3, cpu_gnt3, ldr_gnt3}, 4'b0000);
        RST_n = 1'b1;
        tick;

        // single CPU write of 0xBEEF to 0x0010
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 16'hBEEF;
        tick;
        chk("wr_gnt", {cpu_gnt1, ldr_gnt1, ce1, we1}, 4'b1011);
        chk("wr_addr", addr1, 14'h0010);
        chk("wr_wdata", wdata1, 16'hBEEF);
        chk("wr_no_rvalid", {cpu_rvalid1, ldr_rvalid1}, 2'b00);
        cpu_req = 1'b0;
        tick;
        chk("wr_after", {cpu_gnt1, ce1, cpu_rvalid1, ldr_rvalid1}, 4'b0000);

        // single CPU read of 0x0010
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
        tick;
        chk("rd_gnt", {cpu_gnt1, ce1, we1, busy1}, 4'b1101);
        cpu_req = 1'b0;
        tick;
        chk("rd_t2", {cpu_rvalid1, ldr_rvalid1, busy1}, 3'b001);
        tick;
        chk("rd_t3_rvalid", {cpu_rvalid1, ldr_rvalid1, busy1}, 3'b100);
        chk("rd_t3_rdata", cpu_rdata1, 16'hBEEF);
        tick;
        chk("rd_t4_hold", {cpu_rvalid1, cpu_rdata1}, {1'b0, 16'hBEEF});
        tick;
        chk("rd_lat3_t5", {cpu_rvalid3, ldr_rvalid3, cpu_rdata3}, {2'b10, 16'hBEEF});

        // data for the round-robin reads
        do_write(1'b0, 14'h0001, 16'h1111);
        do_write(1'b1, 14'h0002, 16'h2222);
        tick;

        // round-robin from reset: both reading continuously
        RST_n = 1'b0;
        tick;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0001;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 14'h0002;
        RST_n = 1'b1;
        tick;
        chk("rr_t1", {cpu_gnt1, ldr_gnt1, addr1}, {2'b10, 14'h0001});
        tick;
        chk("rr_t2", {cpu_gnt1, ldr_gnt1, addr1}, {2'b01, 14'h0002});
        tick;
        chk("rr_t3", {cpu_gnt1, ldr_gnt1, cpu_rvalid1, ldr_rvalid1}, 4'b1010);
        chk("rr_t3_data", cpu_rdata1, 16'h1111);
        cpu_req = 1'b0;
        tick;
        chk("rr_t4", {cpu_gnt1, ldr_gnt1, cpu_rvalid1, ldr_rvalid1}, 4'b0101);
        chk("rr_t4_data", ldr_rdata1, 16'h2222);
        ldr_req = 1'b0;
        tick;
        chk("rr_t5", {cpu_gnt1, ldr_gnt1, cpu_rvalid1, ldr_rvalid1, cpu_rdata1}, {4'b0010, 16'h1111});
        tick;
        chk("rr_t6", {cpu_rvalid1, ldr_rvalid1, ldr_rdata1}, {2'b01, 16'h2222});
        tick; tick; tick;

        // gnt masking: CPU alone holds req for 6 cycles
        ng = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010;
        for (int i = 1; i <= 6; i++) begin
            tick;
            chk($sformatf("mask_gnt_%0d", i), {cpu_gnt1, ldr_gnt1}, {(i % 2 == 1), 1'b0});
            if (cpu_gnt1) ng++;
        end
        cpu_req = 1'b0;
        chk("mask_count", ng, 3);
        for (int i = 0; i < 6; i++) tick;

        // reset in the cycle after an LDR read gnt
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 14'h0002;
        tick;
        chk("mr_gnt", ldr_gnt1, 1'b1);
        ldr_req = 1'b0;
        tick;
        RST_n = 1'b0;
        tick;
        RST_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("mr_no_rvalid_%0d", i), {ldr_rvalid1, ldr_rvalid3, cpu_rvalid1, cpu_rvalid3}, 4'b0000);
        end
        chk("mr_busy", {busy1, busy3}, 2'b00);
        chk("mr_rdata", {ldr_rdata1, ldr_rdata3}, 32'h0);

        // loader preload then CPU readback at both latencies
        for (int i = 0; i < 16; i++) do_write(1'b1, 14'(i), 16'(i * 16'h0101));
        for (int i = 0; i < 16; i++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'(i);
            tick;
            chk($sformatf("pl_gnt_%0d", i), {cpu_gnt1, cpu_gnt3}, 2'b11);
            cpu_req = 1'b0;
            tick;
            tick;
            chk($sformatf("pl_lat1_%0d", i), {cpu_rvalid1, ldr_rvalid1, cpu_rdata1}, {2'b10, 16'(i * 16'h0101)});
            chk($sformatf("pl_lat3_early_%0d", i), cpu_rvalid3, 1'b0);
            tick;
            chk($sformatf("pl_lat3_t4_%0d", i), cpu_rvalid3, 1'b0);
            tick;
            chk($sformatf("pl_lat3_%0d", i), {cpu_rvalid3, ldr_rvalid3, cpu_rdata3}, {2'b10, 16'(i * 16'h0101)});
        end
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
